jtkcpu_stkseq: RTL and testbench
================================

# jtkcpu_stkseq

Parametrised stack transfer sequencer for the KONAMI CPU core: given a register-slot mask, it walks the set slots in stack order and issues one byte transfer per step, with wait-state handshaking, abort and a byte tally. It sits between the instruction decoder (PSHS/PSHU/PULS/PULU, interrupt entry, RTI, LBSR/JSR return push) and the memory/ALU datapath. The slot order, the byte order and the slot widths are fixed here, so the decoder only supplies a mask.

## Interface
Parameters:
- NREG, 8, number of register slots; slot NREG-1 is pushed first and pulled last.
- WIDE, 8'hF0, NREG-bit mask; a 1 marks a 16-bit slot (two bytes), a 0 marks an 8-bit slot.
- SW, $clog2(NREG), slot index width (derived).
- CW, $clog2(2*NREG+1), byte counter width (derived).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only on clk edges with cen=1
- start  in  1  begin a sequence; sampled only while idle
- pull  in  1  0=push, 1=pull; latched at start
- use_u  in  1  stack select (1=U, 0=S); latched at start
- mask  in  NREG  slots to transfer; latched at start
- ack  in  1  the current byte transfer completed this cen cycle
- abort  in  1  drop the sequence immediately
- busy  out  1  sequence in progress (includes the done cycle)
- slot  out  SW  index of the current slot
- slot_oh  out  NREG  one-hot of the current slot; 0 when no transfer is active
- hihalf  out  1  current byte is the high byte of a 16-bit slot
- wr  out  1  push byte request (SP pre-decrement + write)
- rd  out  1  pull byte request (read + SP post-increment)
- us_sel  out  1  latched use_u
- done  out  1  one cen-cycle pulse after the last byte is acked
- nbytes  out  CW  bytes acked since start

## Operation
- States: IDLE, XFER, FIN.
- IDLE → XFER when start=1 and the mask is nonzero. Latch pull, use_u and mask, and clear nbytes.
- IDLE → FIN when start=1 and mask=0. No transfer is issued.
- Slot choice: a push takes the highest set bit of the remaining mask; a pull takes the lowest set bit.
- Byte order within a 16-bit slot: a push sends the low byte (hihalf=0) and then the high byte (hihalf=1). A pull sends the high byte first and then the low byte.
- An 8-bit slot always has hihalf=0.
- In XFER, wr=~pull and rd=pull, continuously.
- On ack, nbytes increments. The remaining-mask bit is cleared only after the slot's final byte is acked.
- XFER → FIN when the final byte of the final slot is acked.
- FIN: done=1, busy=1, wr=rd=0, slot_oh=0. FIN → IDLE unconditionally.
- abort in XFER or FIN → IDLE. done is not asserted, nbytes holds its value, and the remaining mask is cleared. abort in IDLE has no effect.
- start while busy is ignored. ack outside XFER is ignored.
- nbytes counts up to the mask byte total and cannot wrap: the maximum is 2*NREG, and CW holds it.

## Timing
- Reset (rst_n=0, asynchronous): IDLE; busy, wr, rd, hihalf, us_sel and done are 0; slot=0, slot_oh=0, nbytes=0.
- Start latency: start is sampled at cen edge N. busy, wr/rd and the first slot/hihalf are valid from edge N until the first ack.
- Each byte takes one or more cen cycles; the outputs hold steady until ack.
- With ack held high, n bytes take n cen cycles, then one FIN cycle.
- Minimum inter-sequence gap: start is accepted in the cen cycle right after FIN.
- All outputs are registered; no combinational path from ack to wr/rd/slot.
- Simultaneous abort and ack: abort wins, and the ack is not counted.

## Structure
- Slot index localparams belong in the shared jtkcpu.inc: CC=0, A=1, B=2, DP=3, X=4, Y=5, U/S=6, PC=7.
- Default WIDE value 8'hF0 also belongs in jtkcpu.inc.
- The fixed masks belong in jtkcpu.inc as well:
  - interrupt-entry mask: FF when E=1, 81 when E=0
  - RTI CC-only mask: 01
  - PC-only mask: 80
- Sub-module jtkcpu_prienc: parametrised W-bit priority encoder with a dir input (0=highest first, 1=lowest first). Outputs are index, one-hot and valid. It is purely combinational, and its outputs are registered in jtkcpu_stkseq.

## Test plan
- Push, mask=8'h81, use_u=0, ack=1 every cycle.
  - Slots in order: PC low, PC high, CC.
  - wr=1 for 3 cycles, then done; nbytes=3; us_sel=0.
- Pull, mask=8'hFF, use_u=1, ack=1.
  - Slot order 0,1,2,3,4(hi,lo),5(hi,lo),6(hi,lo),7(hi,lo).
  - 12 rd cycles, done, nbytes=12.
- Push, mask=8'h10, ack low for 3 cycles between acks.
  - slot=4 and hihalf=0 hold through the wait states, then hihalf=1.
  - done 1 cycle after the second ack; busy spans 9 cycles.
- start with mask=0 → busy=1 and done=1 for one cycle, no wr/rd, nbytes=0.
- Pull, mask=8'hF0, abort together with the third ack → IDLE, no done, nbytes=2; then start with mask=8'h01 → clean sequence, done, nbytes=1.
- Reset mid-sequence and cen gating:
  - rst_n low in XFER gives all outputs 0 immediately.
  - cen=0 with ack=1 freezes every output.

Source files
------------

// File: rtl/jtkcpu_stkseq_pkg.sv
// Shared definitions for the KONAMI CPU stack sequencer: slot numbering, default
// slot widths, fixed decoder masks and the sequencer state encoding.
package jtkcpu_stkseq_pkg;

    localparam int unsigned SLOT_CC = 0;
    localparam int unsigned SLOT_A  = 1;
    localparam int unsigned SLOT_B  = 2;
    localparam int unsigned SLOT_DP = 3;
    localparam int unsigned SLOT_X  = 4;
    localparam int unsigned SLOT_Y  = 5;
    localparam int unsigned SLOT_US = 6;
    localparam int unsigned SLOT_PC = 7;

    // X, Y, U/S and PC are 16-bit; CC, A, B and DP are 8-bit
    localparam logic [7:0] WIDE_DEFAULT = 8'hF0;

    localparam logic [7:0] MASK_RTI_CC = 8'h01;
    localparam logic [7:0] MASK_PC     = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Interrupt entry saves the full frame when E=1, otherwise only PC and CC
    function automatic logic [7:0] irq_entry_mask(input logic e);
        return e ? 8'hFF : 8'h81;
    endfunction

endpackage

// File: rtl/jtkcpu_prienc.sv
// Combinational priority encoder: picks the highest (dir=0) or lowest (dir=1)
// set bit of req and returns its index and one-hot.
module jtkcpu_prienc #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    input  logic          dir,
    output logic [IW-1:0] idx_c,
    output logic [W-1:0]  onehot_c,
    output logic          valid_c
);

    assign valid_c = |req;

    // Later matches overwrite earlier ones, so scan order sets the priority
    always_comb begin
        idx_c = '0;
        if (dir) begin
            for (int i = int'(W) - 1; i >= 0; i--) begin
                if (req[i]) idx_c = IW'(i);
            end
        end else begin
            for (int i = 0; i < int'(W); i++) begin
                if (req[i]) idx_c = IW'(i);
            end
        end
    end

    always_comb begin
        onehot_c = '0;
        if (valid_c) onehot_c = W'(1) << idx_c;
    end

endmodule

// File: rtl/jtkcpu_stkseq.sv
// Stack transfer sequencer: walks the register-slot mask in stack order and
// issues one byte push/pull request per step, with wait states, abort and a tally.
module jtkcpu_stkseq
    import jtkcpu_stkseq_pkg::*;
#(
    parameter int unsigned     NREG = 8,
    parameter logic [NREG-1:0] WIDE = NREG'(WIDE_DEFAULT),
    parameter int unsigned     SW   = $clog2(NREG),
    parameter int unsigned     CW   = $clog2(2*NREG+1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            start,
    input  logic            pull,
    input  logic            use_u,
    input  logic [NREG-1:0] mask,
    input  logic            ack,
    input  logic            abort,
    output logic            busy,
    output logic [SW-1:0]   slot,
    output logic [NREG-1:0] slot_oh,
    output logic            hihalf,
    output logic            wr,
    output logic            rd,
    output logic            us_sel,
    output logic            done,
    output logic [CW-1:0]   nbytes
);

    state_e          state_q, state_d;
    logic            pull_q, pull_d;
    logic            us_sel_q, us_sel_d;
    logic [NREG-1:0] rem_q, rem_d;
    logic            sec_q, sec_d;
    logic [CW-1:0]   nbytes_q, nbytes_d;
    logic            busy_q, busy_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [NREG-1:0] slot_oh_q, slot_oh_d;
    logic            hihalf_q, hihalf_d;
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic            done_q, done_d;

    logic [SW-1:0]   enc_idx_c;
    logic [NREG-1:0] enc_oh_c;
    logic            enc_valid_c;
    logic            cur_last_c;
    logic [NREG-1:0] rem_next_c;

    // sec_q marks that the first byte of a 16-bit slot has already been acked
    assign cur_last_c = ~(|(slot_oh_q & WIDE)) | sec_q;
    assign rem_next_c = rem_q & ~slot_oh_q;

    // Encode the remaining mask as it will be after this edge, so slot outputs can be registered
    jtkcpu_prienc #(
        .W  (NREG),
        .IW (SW)
    ) u_prienc (
        .req      (rem_d),
        .dir      (pull_d),
        .idx_c    (enc_idx_c),
        .onehot_c (enc_oh_c),
        .valid_c  (enc_valid_c)
    );

    always_comb begin
        state_d  = state_q;
        pull_d   = pull_q;
        us_sel_d = us_sel_q;
        rem_d    = rem_q;
        sec_d    = sec_q;
        nbytes_d = nbytes_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pull_d   = pull;
                    us_sel_d = use_u;
                    nbytes_d = '0;
                    sec_d    = 1'b0;
                    rem_d    = mask;
                    state_d  = (|mask) ? ST_XFER : ST_FIN;
                end
            end
            ST_XFER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    sec_d   = 1'b0;
                end else if (ack) begin
                    nbytes_d = nbytes_q + CW'(1);
                    if (!cur_last_c) begin
                        sec_d = 1'b1;
                    end else begin
                        sec_d = 1'b0;
                        rem_d = rem_next_c;
                        if (rem_next_c == '0) state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                rem_d   = '0;
                sec_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
                sec_d   = 1'b0;
            end
        endcase
    end

    // Output decode from the next state; pulls send the high byte first
    always_comb begin
        busy_d    = 1'b0;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        hihalf_d  = 1'b0;
        done_d    = 1'b0;
        slot_d    = '0;
        slot_oh_d = '0;
        unique case (state_d)
            ST_XFER: begin
                busy_d = 1'b1;
                wr_d   = ~pull_d;
                rd_d   = pull_d;
                if (enc_valid_c) begin
                    slot_d    = enc_idx_c;
                    slot_oh_d = enc_oh_c;
                    hihalf_d  = (|(enc_oh_c & WIDE)) & (pull_d ^ sec_d);
                end
            end
            ST_FIN: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pull_q    <= 1'b0;
            us_sel_q  <= 1'b0;
            rem_q     <= '0;
            sec_q     <= 1'b0;
            nbytes_q  <= '0;
            busy_q    <= 1'b0;
            slot_q    <= '0;
            slot_oh_q <= '0;
            hihalf_q  <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            done_q    <= 1'b0;
        end else if (cen) begin
            state_q   <= state_d;
            pull_q    <= pull_d;
            us_sel_q  <= us_sel_d;
            rem_q     <= rem_d;
            sec_q     <= sec_d;
            nbytes_q  <= nbytes_d;
            busy_q    <= busy_d;
            slot_q    <= slot_d;
            slot_oh_q <= slot_oh_d;
            hihalf_q  <= hihalf_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign slot    = slot_q;
    assign slot_oh = slot_oh_q;
    assign hihalf  = hihalf_q;
    assign wr      = wr_q;
    assign rd      = rd_q;
    assign us_sel  = us_sel_q;
    assign done    = done_q;
    assign nbytes  = nbytes_q;

endmodule

// File: tb/tb_jtkcpu_stkseq.sv
// Directed bench for jtkcpu_stkseq: per-cycle vector table plus hand sequences
// for asynchronous reset and clock-enable gating.
module tb_jtkcpu_stkseq;
    import jtkcpu_stkseq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, cen, start, pull, use_u, ack, abort;
    logic [7:0] mask;
    logic       busy, hihalf, wr, rd, us_sel, done;
    logic [2:0] slot;
    logic [7:0] slot_oh;
    logic [4:0] nbytes;

    int n_checks = 0;
    int n_fail   = 0;

    jtkcpu_stkseq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .start   (start),
        .pull    (pull),
        .use_u   (use_u),
        .mask    (mask),
        .ack     (ack),
        .abort   (abort),
        .busy    (busy),
        .slot    (slot),
        .slot_oh (slot_oh),
        .hihalf  (hihalf),
        .wr      (wr),
        .rd      (rd),
        .us_sel  (us_sel),
        .done    (done),
        .nbytes  (nbytes)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual running, required finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        start;
        logic        pull;
        logic        use_u;
        logic [7:0]  mask;
        logic        ack;
        logic        abort;
        logic [21:0] exp;
    } vec_t;

    vec_t vq[$];

    // Packed layout: busy, wr, rd, hihalf, done, us_sel, slot, slot_oh, nbytes
    function automatic logic [21:0] ex(input logic b, w, r, input int s,
                                       input logic h, d, u, input int nb);
        logic [7:0] oh;
        oh = (w | r) ? (8'd1 << s) : 8'd0;
        return {b, w, r, h, d, u, 3'(s), oh, 5'(nb)};
    endfunction

    function automatic logic [21:0] xf(input logic pl, u, input int s, input logic h, input int nb);
        return ex(1'b1, ~pl, pl, s, h, 1'b0, u, nb);
    endfunction

    function automatic logic [21:0] fin(input logic u, input int nb);
        return ex(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, u, nb);
    endfunction

    function automatic logic [21:0] idl(input logic u, input int nb);
        return ex(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, u, nb);
    endfunction

    function automatic string fmt(input logic [21:0] v);
        return $sformatf("busy=%0b wr=%0b rd=%0b hihalf=%0b done=%0b us_sel=%0b slot=%0d slot_oh=%02h nbytes=%0d",
                         v[21], v[20], v[19], v[18], v[17], v[16], v[15:13], v[12:5], v[4:0]);
    endfunction

    function automatic void add(input string nm, input logic st, pl, uu, input logic [7:0] m,
                                input logic ak, ab, input logic [21:0] e);
        vec_t v;
        v.name = nm; v.start = st; v.pull = pl; v.use_u = uu; v.mask = m;
        v.ack = ak; v.abort = ab; v.exp = e;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [21:0] e);
        logic [21:0] act;
        act = {busy, wr, rd, hihalf, done, us_sel, slot, slot_oh, nbytes};
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: actual %s, required %s", name, fmt(act), fmt(e));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         ps[12] = '{0, 1, 2, 3, 4, 4, 5, 5, 6, 6, 7, 7};
        logic [7:0] m81, mff;
        logic       ph[12];
        ph  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        m81 = irq_entry_mask(1'b0);
        mff = irq_entry_mask(1'b1);

        // Push PC+CC with continuous ack: PC low, PC high, CC
        add("push81_start", 1, 0, 0, m81, 1, 0, xf(0, 0, 7, 0, 0));
        add("push81_b1",    0, 0, 0, m81, 1, 0, xf(0, 0, 7, 1, 1));
        add("push81_b2",    0, 0, 0, m81, 1, 0, xf(0, 0, 0, 0, 2));
        add("push81_fin",   0, 0, 0, m81, 1, 0, fin(0, 3));
        add("busy_start_ignored", 1, 1, 1, 8'h3C, 1, 0, idl(0, 3));

        // Pull everything on U: lowest slot first, high byte before low byte
        add("pullff_start", 1, 1, 1, mff, 1, 0, xf(1, 1, ps[0], ph[0], 0));
        for (int k = 1; k < 12; k++)
            add($sformatf("pullff_b%0d", k), 0, 1, 1, mff, 1, 0, xf(1, 1, ps[k], ph[k], k));
        add("pullff_fin",  0, 1, 1, mff, 1, 0, fin(1, 12));
        add("pullff_idle", 0, 1, 1, mff, 1, 0, idl(1, 12));

        // Empty mask: one FIN cycle, no transfer
        add("mask0_fin",  1, 0, 0, 8'h00, 0, 0, fin(0, 0));
        add("mask0_idle", 0, 0, 0, 8'h00, 0, 0, idl(0, 0));
        add("idle_ack_abort_ignored", 0, 0, 0, 8'h00, 1, 1, idl(0, 0));

        // Push X with three wait states before each ack
        add("x_wait_start", 1, 0, 0, 8'h10, 0, 0, xf(0, 0, 4, 0, 0));
        for (int k = 0; k < 3; k++) add("x_wait_lo", 0, 0, 0, 8'h10, 0, 0, xf(0, 0, 4, 0, 0));
        add("x_ack_lo", 0, 0, 0, 8'h10, 1, 0, xf(0, 0, 4, 1, 1));
        for (int k = 0; k < 3; k++) add("x_wait_hi", 0, 0, 0, 8'h10, 0, 0, xf(0, 0, 4, 1, 1));
        add("x_fin",  0, 0, 0, 8'h10, 1, 0, fin(0, 2));
        add("x_idle", 0, 0, 0, 8'h10, 0, 0, idl(0, 2));

        // Abort on the third ack wins over the ack, then a clean CC-only pull
        add("ab_start", 1, 1, 1, 8'hF0, 1, 0, xf(1, 1, 4, 1, 0));
        add("ab_b1",    0, 1, 1, 8'hF0, 1, 0, xf(1, 1, 4, 0, 1));
        add("ab_b2",    0, 1, 1, 8'hF0, 1, 0, xf(1, 1, 5, 1, 2));
        add("ab_abort", 0, 1, 1, 8'hF0, 1, 1, idl(1, 2));
        add("ab_nodone",0, 1, 1, 8'hF0, 0, 0, idl(1, 2));
        add("cc_start", 1, 1, 0, MASK_RTI_CC, 0, 0, xf(1, 0, 0, 0, 0));
        add("cc_fin",   0, 1, 0, MASK_RTI_CC, 1, 0, fin(0, 1));
        add("cc_idle",  0, 1, 0, MASK_RTI_CC, 0, 0, idl(0, 1));

        rst_n = 1'b0; cen = 1'b1; start = 1'b0; pull = 1'b0; use_u = 1'b0;
        mask = 8'h00; ack = 1'b0; abort = 1'b0;
        #12;
        check("reset", idl(0, 0));
        rst_n = 1'b1;

        foreach (vq[i]) begin
            start = vq[i].start; pull = vq[i].pull; use_u = vq[i].use_u;
            mask = vq[i].mask; ack = vq[i].ack; abort = vq[i].abort;
            tick();
            check(vq[i].name, vq[i].exp);
        end
        start = 1'b0; ack = 1'b0; abort = 1'b0;

        // Asynchronous reset in the middle of a push
        start = 1'b1; pull = 1'b0; use_u = 1'b1; mask = 8'hFF;
        tick();
        start = 1'b0;
        check("rst_pre", xf(0, 1, 7, 0, 0));
        #2 rst_n = 1'b0;
        #1 check("rst_async", idl(0, 0));
        #3 rst_n = 1'b1;

        // Clock enable low freezes everything even with ack high
        start = 1'b1; pull = 1'b0; use_u = 1'b0; mask = 8'hC0; ack = 1'b1;
        tick();
        start = 1'b0;
        check("cen_start", xf(0, 0, 7, 0, 0));
        cen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("cen_hold", xf(0, 0, 7, 0, 0));
        end
        cen = 1'b1;
        tick();
        check("cen_resume", xf(0, 0, 7, 1, 1));
        abort = 1'b1;
        tick();
        abort = 1'b0; ack = 1'b0;
        check("cen_abort", idl(0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
